j1_io_responder: RTL and testbench

- Memory-mapped I/O target on the core's I/O bus: decodes io_rd/io_wr strobes with the 16-bit address and returns read data on io_din in the same cycle.
- Contains a GPIO output register, synchronized GPIO inputs, an 8N1 UART transmitter with a small FIFO, a UART receiver with a one-byte holding register, and a loadable 16-bit tick counter.
- Sits between the CPU core's io_* / mem_addr / dout signals and the board pins.

---
 rtl/j1_io_responder.sv | 172 +++++++++++++++++
 tb/tb_j1_io_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_io_responder.sv
// j1_io_responder: memory-mapped GPIO, UART TX/RX and tick counter on the J1 I/O bus
module j1_io_responder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic wr_gpio, wr_tick, push, rd_status, rd_rx;
  logic [15:0] gpio_meta, gpio_s, tick, status;
  logic rx_meta, rx_s, rx_prev;
  logic [7:0] fifo [TX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic tx_full, tx_empty, push_ok, tx_pop, tx_bit_end, tx_busy;
  state_t tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_sh;
  state_t rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_idx;
  logic [7:0] rx_sh, rx_byte;
  logic rx_half, rx_bit_end, rx_done, rx_ok, rx_valid, rx_overrun, rx_frame_err, tx_overflow;
  assign wr_gpio   = io_wr && mem_addr == 16'h0000;
  assign push      = io_wr && mem_addr == 16'h0002;
  assign wr_tick   = io_wr && mem_addr == 16'h0005;
  assign rd_status = io_rd && mem_addr == 16'h0003;
  assign rd_rx     = io_rd && mem_addr == 16'h0004;
  assign tx_full   = count == (AW+1)'(TX_DEPTH);
  assign tx_empty  = count == '0;
  assign push_ok   = push && !tx_full;
  assign tx_busy   = !tx_empty || tx_state != IDLE;
  assign status    = {10'd0, tx_overflow, rx_frame_err, rx_overrun, rx_valid, tx_busy, tx_full};
  assign uart_tx   = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
  // Read mux: zero unless a read is in progress outside reset
  always_comb
    io_din = !(io_rd && resetq)        ? 16'h0000 :
             mem_addr == 16'h0000      ? gpio_out :
             mem_addr == 16'h0001      ? gpio_s :
             mem_addr == 16'h0003      ? status :
             mem_addr == 16'h0004      ? {8'h00, rx_byte} :
             mem_addr == 16'h0005      ? tick : 16'h0000;
  // Synchronizers, GPIO output register and free-running tick
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      gpio_meta <= '0;
      gpio_s    <= '0;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      gpio_out  <= '0;
      tick      <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_s    <= gpio_meta;
      rx_meta   <= uart_rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      if (wr_gpio) gpio_out <= dout;
      tick      <= wr_tick ? dout : tick + 16'd1;
    end
  // TX FIFO storage; contents are invalidated by the pointer reset alone
  always_ff @(posedge clk)
    if (push_ok) fifo[wp] <= dout[7:0];
  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (tx_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(tx_pop);
    end
  assign tx_bit_end = tx_cnt == CW'(CLKS_PER_BIT - 1);
  // TX state register
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) tx_state <= IDLE;
    else tx_state <= tx_next;
  // TX next state; a pop loads the shifter and starts a frame back-to-back
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:  if (!tx_empty) begin
        tx_next = START;
        tx_pop  = 1'b1;
      end
      START: if (tx_bit_end) tx_next = DATA;
      DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = STOP;
      STOP:  if (tx_bit_end) begin
        tx_next = tx_empty ? IDLE : START;
        tx_pop  = !tx_empty;
      end
    endcase
  end
  // TX bit timer and shifter
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
    end else begin
      tx_cnt <= (tx_state == IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
      if (tx_pop) tx_sh <= fifo[rp];
      else if (tx_state == DATA && tx_bit_end) tx_sh <= tx_sh >> 1;
      if (tx_state == DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
    end
  assign rx_half    = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign rx_bit_end = rx_cnt == CW'(CLKS_PER_BIT - 1);
  assign rx_ok      = rx_done && rx_s;
  // RX state register
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) rx_state <= IDLE;
    else rx_state <= rx_next;
  // RX next state; start bit re-checked at mid-bit to reject glitches
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      IDLE:  if (rx_prev && !rx_s) rx_next = START;
      START: if (rx_half) rx_next = rx_s ? IDLE : DATA;
      DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = STOP;
      STOP:  if (rx_bit_end) begin
        rx_next = IDLE;
        rx_done = 1'b1;
      end
    endcase
  end
  // RX bit timer and LSB-first assembler
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
    end else begin
      rx_cnt <= (rx_next != rx_state || rx_bit_end) ? '0 : rx_cnt + 1'b1;
      if (rx_state == DATA && rx_bit_end) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_idx <= rx_idx + 3'd1;
      end
    end
  // RX holding register and sticky flags; a new event wins over a clearing read
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (rx_ok && (!rx_valid || rd_rx)) rx_byte <= rx_sh;
      rx_valid     <= rx_ok || (rx_valid && !rd_rx);
      rx_overrun   <= (rx_overrun && !rd_status) || (rx_ok && rx_valid && !rd_rx);
      rx_frame_err <= (rx_frame_err && !rd_status) || (rx_done && !rx_s);
      tx_overflow  <= (tx_overflow && !rd_status) || (push && tx_full);
    end
endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: table vectors plus randomized UART/tick/GPIO checks against a behavioural model
module tb_j1_io_responder;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0, resetq = 1'b0, io_rd = 1'b0, io_wr = 1'b0, uart_rx = 1'b1;
  logic [15:0] mem_addr = '0, dout = '0, gpio_in = '0;
  logic [15:0] io_din, gpio_out;
  logic uart_tx;
  int total = 0, bad = 0;
  bit cap = 1'b0;
  logic txq [$];
  logic [7:0] txb [$];
  typedef struct {
    logic rd;
    logic wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_din;
    logic [15:0] exp_gpio;
  } vec_t;
  vec_t vt [15];

  j1_io_responder #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
    .mem_addr(mem_addr), .dout(dout), .io_din(io_din),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap) txq.push_back(uart_tx);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a;
    dout = d;
    io_wr = 1'b1;
    cyc();
    io_wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string name);
    mem_addr = a;
    io_rd = 1'b1;
    #1;
    chk(name, io_din, exp);
    cyc();
    io_rd = 1'b0;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  // Expected line: two idle samples, then contiguous frames of the accepted bytes, then idle
  task automatic tx_verify(input int sent);
    int pos, err;
    err = (txq.size() < 2 || txq[0] !== 1'b1 || txq[1] !== 1'b1) ? 1 : 0;
    chk("tx lead idle", 16'(err), 16'd0);
    pos = 2;
    for (int f = 0; f < sent; f++) begin
      err = 0;
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < CPB; c++) begin
          if (pos >= txq.size() || txq[pos] !== fbit(txb[f], k)) err++;
          pos++;
        end
      chk($sformatf("tx frame %0d", f), 16'(err), 16'd0);
    end
    err = 0;
    for (int i = pos; i < txq.size(); i++) if (txq[i] !== 1'b1) err++;
    chk("tx tail idle", 16'(err), 16'd0);
  endtask

  // Back-to-back pushes: one is popped immediately, DEPTH more fit, the rest overflow
  task automatic tx_round(input bit mid);
    int sent;
    sent = txb.size() < DEPTH + 1 ? txb.size() : DEPTH + 1;
    txq.delete();
    cap = 1'b1;
    foreach (txb[i]) wr(16'h0002, {8'h00, txb[i]});
    if (mid) begin
      repeat (3 * CPB) cyc();
      rd_chk(16'h0003, 16'h0002, "status busy mid-frame");
    end
    repeat (sent * 10 * CPB + 4) cyc();
    rd_chk(16'h0003, txb.size() > DEPTH + 1 ? 16'h0020 : 16'h0000, "status after tx");
    rd_chk(16'h0003, 16'h0000, "status after clear");
    cap = 1'b0;
    tx_verify(sent);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) cyc();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) cyc();
    end
    uart_rx = stop;
    repeat (CPB) cyc();
    uart_rx = 1'b1;
    repeat (2 * CPB) cyc();
  endtask

  initial begin
    logic [15:0] r, prev, nv;
    int k, n;
    vt[0]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h1234};
    vt[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1234};
    vt[5]  = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 16'h1234};
    vt[6]  = '{1'b0, 1'b1, 16'h00FF, 16'hBEEF, 16'h0000, 16'h1234};
    vt[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 16'h1234};
    vt[8]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h1234};
    vt[9]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h1234};
    vt[10] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h1234};
    vt[11] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h1234, 16'hFFFF};
    vt[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    vt[13] = '{1'b0, 1'b1, 16'h0006, 16'h5555, 16'h0000, 16'hFFFF};
    vt[14] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'hFFFF};
    repeat (3) cyc();
    chk("reset uart_tx", {15'd0, uart_tx}, 16'd1);
    chk("reset gpio_out", gpio_out, 16'h0000);
    resetq = 1'b1;
    cyc();
    foreach (vt[i]) begin
      io_rd = vt[i].rd;
      io_wr = vt[i].wr;
      mem_addr = vt[i].addr;
      dout = vt[i].data;
      #1;
      chk($sformatf("vec%0d io_din", i), io_din, vt[i].exp_din);
      cyc();
      io_rd = 1'b0;
      io_wr = 1'b0;
      chk($sformatf("vec%0d gpio_out", i), gpio_out, vt[i].exp_gpio);
    end
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      wr(16'h0000, r);
      rd_chk(16'h0000, r, "gpio_out rand");
      chk("gpio_out pin", gpio_out, r);
    end
    prev = gpio_in;
    for (int i = 0; i < 6; i++) begin
      nv = prev ^ (16'($urandom) | 16'h0001);
      gpio_in = nv;
      cyc();
      rd_chk(16'h0001, prev, "gpio_in sync delay");
      rd_chk(16'h0001, nv, "gpio_in synced");
      prev = nv;
    end
    wr(16'h0005, 16'hFFFE);
    cyc();
    rd_chk(16'h0005, 16'hFFFF, "tick ffff");
    rd_chk(16'h0005, 16'h0000, "tick wrap");
    rd_chk(16'h0005, 16'h0001, "tick 0001");
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      k = $urandom_range(0, 20);
      wr(16'h0005, r);
      repeat (k) cyc();
      rd_chk(16'h0005, r + 16'(k), "tick rand");
    end
    txb.delete();
    txb.push_back(8'hA5);
    tx_round(1'b1);
    txb.delete();
    for (int i = 0; i < 6; i++) txb.push_back(8'($urandom));
    tx_round(1'b0);
    for (int j = 0; j < 3; j++) begin
      txb.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
      tx_round(1'b0);
    end
    send(8'h3C, 1'b1);
    rd_chk(16'h0003, 16'h0004, "rx valid");
    send(8'h7E, 1'b1);
    rd_chk(16'h0003, 16'h000C, "rx overrun");
    rd_chk(16'h0004, 16'h003C, "rx keeps first byte");
    rd_chk(16'h0003, 16'h0000, "rx cleared");
    send(8'h55, 1'b0);
    rd_chk(16'h0003, 16'h0010, "rx frame err");
    rd_chk(16'h0003, 16'h0000, "rx frame err cleared");
    rd_chk(16'h0004, 16'h003C, "rx bad frame discarded");
    uart_rx = 1'b0;
    cyc();
    uart_rx = 1'b1;
    repeat (5 * CPB) cyc();
    rd_chk(16'h0003, 16'h0000, "rx glitch ignored");
    for (int i = 0; i < 4; i++) begin
      r = {8'h00, 8'($urandom)};
      send(r[7:0], 1'b1);
      rd_chk(16'h0004, r, "rx rand byte");
      rd_chk(16'h0003, 16'h0000, "rx rand status");
    end
    wr(16'h0000, 16'h1234);
    wr(16'h0002, 16'h0000);
    wr(16'h0002, 16'h0011);
    wr(16'h0002, 16'h0022);
    repeat (6) cyc();
    chk("pre-reset uart_tx low", {15'd0, uart_tx}, 16'd0);
    #2;
    resetq = 1'b0;
    #1;
    chk("reset mid-frame uart_tx", {15'd0, uart_tx}, 16'd1);
    chk("reset mid-frame gpio_out", gpio_out, 16'h0000);
    io_rd = 1'b1;
    mem_addr = 16'h0000;
    #1;
    chk("reset io_din", io_din, 16'h0000);
    io_rd = 1'b0;
    cyc();
    resetq = 1'b1;
    cyc();
    rd_chk(16'h0003, 16'h0000, "post-reset fifo empty");
    k = 0;
    for (int i = 0; i < 5 * CPB; i++) begin
      if (uart_tx !== 1'b1) k++;
      cyc();
    end
    chk("post-reset line idle", 16'(k), 16'd0);
    rd_chk(16'h0003, 16'h0000, "post-reset status");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
